// File: rtl/conv_seq_pkg.sv
// Shared types and size helpers for the convolution layer sequencer.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IN,
    LOAD_W,
    LOAD_B,
    START,
    RUN,
    DONE
  } state_t;

  function automatic int calc_n_in(input int c, input int h, input int w);
    return c * h * w;
  endfunction

  function automatic int calc_n_w(input int k, input int c, input int ks);
    return k * c * ks * ks;
  endfunction

  function automatic int calc_n_b(input int k);
    return k;
  endfunction

  function automatic int calc_n_out(input int k, input int h, input int w, input int ks);
    return k * (h - ks + 1) * (w - ks + 1);
  endfunction

  // A one-entry memory still needs a 1-bit address port.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/conv_seq_bias_packer.sv
// Assembles four stream bytes, little-endian, into one 32-bit bias word.
module conv_seq_bias_packer
  import conv_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_cnt;
  logic [23:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= '0;
      shreg      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        byte_cnt <= '0;
        shreg    <= '0;
      end else if (byte_valid) begin
        // Earlier bytes shift down so the first byte ends up in bits 7:0.
        if (byte_cnt == 2'd3) begin
          word       <= {byte_data, shreg};
          word_valid <= 1'b1;
        end else begin
          shreg <= {byte_data, shreg[23:8]};
        end
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Loads inputs/weights/biases from one byte stream, starts the engine, forwards results.
// Optional watchdog on the RUN state: define CONV_SEQ_WATCHDOG_EN.
module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int INPUT_CHANNELS  = 1,
  parameter int OUTPUT_CHANNELS = 32,
  parameter int KERNEL_SIZE     = 3,
  parameter int INPUT_WIDTH     = 30,
  parameter int INPUT_HEIGHT    = 30,
  parameter int WDOG_CYCLES     = 1000000,
  localparam int N_IN  = calc_n_in(INPUT_CHANNELS, INPUT_HEIGHT, INPUT_WIDTH),
  localparam int N_W   = calc_n_w(OUTPUT_CHANNELS, INPUT_CHANNELS, KERNEL_SIZE),
  localparam int N_B   = calc_n_b(OUTPUT_CHANNELS),
  localparam int N_OUT = calc_n_out(OUTPUT_CHANNELS, INPUT_HEIGHT, INPUT_WIDTH, KERNEL_SIZE),
  localparam int IN_AW = addr_width(N_IN),
  localparam int W_AW  = addr_width(N_W),
  localparam int B_AW  = addr_width(N_B),
  localparam int OUT_W = addr_width(N_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_start,
  output logic             busy,
  output logic             layer_done,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             conv_start,
  input  logic             conv_done,
  output logic [7:0]       input_data_in,
  output logic             input_data_we,
  output logic [IN_AW-1:0] input_data_addr,
  output logic [7:0]       weight_data_in,
  output logic             weight_data_we,
  output logic [W_AW-1:0]  weight_data_addr,
  output logic [31:0]      bias_data_in,
  output logic             bias_data_we,
  output logic [B_AW-1:0]  bias_data_addr,
  input  logic [7:0]       conv_result,
  input  logic             conv_valid,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic [OUT_W-1:0] out_count,
  output logic             wdog_err
);

  // One counter serves every load phase; bias bytes need two extra low bits.
  localparam int CNT_W = max_int(addr_width(max_int(max_int(N_IN, N_W), 4 * N_B)), B_AW + 2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             done_seen;
  logic             xfer;
  logic             start_ok;
  logic             bias_byte;
  logic             wdog_fire;
  logic             run_finished;

  assign s_ready      = (state == LOAD_IN) || (state == LOAD_W) || (state == LOAD_B);
  assign xfer         = s_valid && s_ready;
  assign start_ok     = cmd_start && (state == IDLE);
  assign bias_byte    = xfer && (state == LOAD_B);
  assign run_finished = (done_seen && (out_count == OUT_W'(N_OUT))) || wdog_fire;

  conv_seq_bias_packer u_bias_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_ok),
    .byte_valid (bias_byte),
    .byte_data  (s_data),
    .word       (bias_data_in),
    .word_valid (bias_data_we)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the value from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      done_seen        <= 1'b0;
      busy             <= 1'b0;
      layer_done       <= 1'b0;
      conv_start       <= 1'b0;
      input_data_in    <= '0;
      input_data_we    <= 1'b0;
      input_data_addr  <= '0;
      weight_data_in   <= '0;
      weight_data_we   <= 1'b0;
      weight_data_addr <= '0;
      bias_data_addr   <= '0;
      m_data           <= '0;
      m_valid          <= 1'b0;
      out_count        <= '0;
    end else begin
      input_data_we  <= 1'b0;
      weight_data_we <= 1'b0;
      conv_start     <= 1'b0;
      layer_done     <= 1'b0;
      m_valid        <= conv_valid && (state == RUN);

      case (state)
        IDLE: begin
          if (cmd_start) begin
            state     <= LOAD_IN;
            busy      <= 1'b1;
            cnt       <= '0;
            done_seen <= 1'b0;
            out_count <= '0;
          end
        end

        LOAD_IN: begin
          if (xfer) begin
            input_data_we   <= 1'b1;
            input_data_addr <= cnt[IN_AW-1:0];
            input_data_in   <= s_data;
            if (cnt == CNT_W'(N_IN - 1)) begin
              cnt   <= '0;
              state <= LOAD_W;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        LOAD_W: begin
          if (xfer) begin
            weight_data_we   <= 1'b1;
            weight_data_addr <= cnt[W_AW-1:0];
            weight_data_in   <= s_data;
            if (cnt == CNT_W'(N_W - 1)) begin
              cnt   <= '0;
              state <= LOAD_B;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        LOAD_B: begin
          // The packer raises the write itself; only the address is tracked here.
          if (xfer) begin
            if (cnt[1:0] == 2'd3) bias_data_addr <= cnt[B_AW+1:2];
            if (cnt == CNT_W'(4 * N_B - 1)) begin
              cnt        <= '0;
              state      <= START;
              conv_start <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        START: state <= RUN;

        RUN: begin
          if (conv_valid) begin
            m_data <= conv_result;
            if (out_count != OUT_W'(N_OUT)) out_count <= out_count + 1'b1;
          end
          if (conv_done) done_seen <= 1'b1;
          if (run_finished) begin
            state      <= DONE;
            layer_done <= 1'b1;
            busy       <= 1'b0;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONV_SEQ_WATCHDOG_EN
  localparam int WD_W = addr_width(WDOG_CYCLES + 1);

  logic [WD_W-1:0] wdog_cnt;

  assign wdog_fire = (state == RUN) && !conv_valid && (wdog_cnt == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if ((state != RUN) || conv_valid) wdog_cnt <= '0;
      else                              wdog_cnt <= wdog_cnt + 1'b1;
      if (start_ok)       wdog_err <= 1'b0;
      else if (wdog_fire) wdog_err <= 1'b1;
    end
  end
`else
  assign wdog_fire = 1'b0;
  // Constant 0 for any legal limit; keeps the parameter referenced in this build.
  assign wdog_err  = (WDOG_CYCLES < 0);
`endif

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Self-checking bench: randomized loads and engine traffic against a stream-level reference.
module tb_conv_layer_sequencer;

  localparam int N_IN    = 900;
  localparam int N_W     = 288;
  localparam int N_B     = 32;
  localparam int N_OUT   = 25088;
  localparam int N_BYTES = N_IN + N_W + 4 * N_B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic        busy, layer_done;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        conv_start;
  logic        conv_done = 1'b0;
  logic [7:0]  input_data_in;
  logic        input_data_we;
  logic [9:0]  input_data_addr;
  logic [7:0]  weight_data_in;
  logic        weight_data_we;
  logic [8:0]  weight_data_addr;
  logic [31:0] bias_data_in;
  logic        bias_data_we;
  logic [4:0]  bias_data_addr;
  logic [7:0]  conv_result = '0;
  logic        conv_valid = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic [14:0] out_count;
  logic        wdog_err;

  always #5 clk = ~clk;

  conv_layer_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_start        (cmd_start),
    .busy             (busy),
    .layer_done       (layer_done),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .conv_start       (conv_start),
    .conv_done        (conv_done),
    .input_data_in    (input_data_in),
    .input_data_we    (input_data_we),
    .input_data_addr  (input_data_addr),
    .weight_data_in   (weight_data_in),
    .weight_data_we   (weight_data_we),
    .weight_data_addr (weight_data_addr),
    .bias_data_in     (bias_data_in),
    .bias_data_we     (bias_data_we),
    .bias_data_addr   (bias_data_addr),
    .conv_result      (conv_result),
    .conv_valid       (conv_valid),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .out_count        (out_count),
    .wdog_err         (wdog_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference: the byte stream itself defines every expected write.
  logic [7:0]  stream[$];
  logic [7:0]  exp_m[$];

  int          in_addr_q[$];
  logic [7:0]  in_data_q[$];
  int          w_addr_q[$];
  logic [7:0]  w_data_q[$];
  int          b_addr_q[$];
  logic [31:0] b_data_q[$];

  int cyc = 0;
  int xfer_cnt, start_cnt, done_cnt, mv_cnt, mv_bad, lat_err, multi_we_err, ready_miss;
  int last_mv_cyc, done_cyc;
  logic prev_xfer = 1'b0;

  always @(negedge clk) begin
    int nwe;
    cyc++;
    nwe = int'(input_data_we) + int'(weight_data_we) + int'(bias_data_we);
    if (!rst) begin
      if (nwe > 0 && !prev_xfer) lat_err++;
      if (nwe > 1) multi_we_err++;
      if (input_data_we) begin
        in_addr_q.push_back(int'(input_data_addr));
        in_data_q.push_back(input_data_in);
      end
      if (weight_data_we) begin
        w_addr_q.push_back(int'(weight_data_addr));
        w_data_q.push_back(weight_data_in);
      end
      if (bias_data_we) begin
        b_addr_q.push_back(int'(bias_data_addr));
        b_data_q.push_back(bias_data_in);
      end
      if (s_valid && s_ready) xfer_cnt++;
      if (conv_start) start_cnt++;
      if (layer_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (m_valid) begin
        mv_cnt++;
        last_mv_cyc = cyc;
        if (exp_m.size() == 0) mv_bad++;
        else if (exp_m.pop_front() !== m_data) mv_bad++;
      end
    end
    prev_xfer = s_valid && s_ready && !rst;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    in_addr_q.delete(); in_data_q.delete();
    w_addr_q.delete();  w_data_q.delete();
    b_addr_q.delete();  b_data_q.delete();
    exp_m.delete();
    xfer_cnt = 0; start_cnt = 0; done_cnt = 0; mv_cnt = 0; mv_bad = 0;
    lat_err = 0; multi_we_err = 0; ready_miss = 0; last_mv_cyc = 0; done_cyc = 0;
  endtask

  task automatic new_stream();
    stream.delete();
    for (int i = 0; i < N_BYTES; i++) stream.push_back(8'($urandom));
  endtask

  task automatic start_layer();
    cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic load_stream(input int gap_pct, input int stop_at, input int busy_pulse_at);
    for (int i = 0; i < stream.size() && i < stop_at; i++) begin
      if (i == busy_pulse_at) begin
        s_valid   = 1'b0;
        cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
      end
      while ($urandom_range(0, 99) < gap_pct) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (!s_ready) ready_miss++;
      s_valid = 1'b1;
      s_data  = stream[i];
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic verify_load();
    int bad;
    logic [31:0] exp_b;
    check("load_transfers", 64'(xfer_cnt), 64'(N_BYTES));
    check("load_ready_high", 64'(ready_miss), 64'd0);
    check("in_write_count", 64'(in_addr_q.size()), 64'(N_IN));
    bad = 0;
    for (int i = 0; i < in_addr_q.size() && i < N_IN; i++)
      if (in_addr_q[i] != i || in_data_q[i] !== stream[i]) bad++;
    check("in_write_content", 64'(bad), 64'd0);
    check("w_write_count", 64'(w_addr_q.size()), 64'(N_W));
    bad = 0;
    for (int i = 0; i < w_addr_q.size() && i < N_W; i++)
      if (w_addr_q[i] != i || w_data_q[i] !== stream[N_IN + i]) bad++;
    check("w_write_content", 64'(bad), 64'd0);
    check("b_write_count", 64'(b_addr_q.size()), 64'(N_B));
    bad = 0;
    for (int b = 0; b < b_addr_q.size() && b < N_B; b++) begin
      exp_b = {stream[N_IN + N_W + 4*b + 3], stream[N_IN + N_W + 4*b + 2],
               stream[N_IN + N_W + 4*b + 1], stream[N_IN + N_W + 4*b]};
      if (b_addr_q[b] != b || b_data_q[b] !== exp_b) bad++;
    end
    check("b_write_content", 64'(bad), 64'd0);
    check("we_latency", 64'(lat_err), 64'd0);
    check("we_one_per_cycle", 64'(multi_we_err), 64'd0);
    check("conv_start_pulses", 64'(start_cnt), 64'd1);
  endtask

  // done_at >= 0: conv_done rides along with that output; otherwise it follows the last one.
  task automatic run_engine(input int n_valid, input int done_at, input int gap_pct);
    for (int i = 0; i < n_valid; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        conv_valid = 1'b0;
        conv_done  = 1'b0;
        @(posedge clk); #1;
      end
      conv_valid  = 1'b1;
      conv_result = 8'($urandom);
      conv_done   = (i == done_at);
      exp_m.push_back(conv_result);
      @(posedge clk); #1;
    end
    conv_valid = 1'b0;
    conv_done  = 1'b0;
    if (done_at < 0) begin
      conv_done = 1'b1;
      @(posedge clk); #1;
      conv_done = 1'b0;
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt == 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("layer_done_pulses", 64'(done_cnt), 64'd1);
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 64'({busy, layer_done, s_ready, conv_start, m_valid, wdog_err, m_data, out_count}), 64'd0);
    check({tag, "_mem"}, 64'({input_data_we, input_data_in, input_data_addr,
                              weight_data_we, weight_data_in, weight_data_addr}), 64'd0);
    check({tag, "_bias"}, 64'({bias_data_we, bias_data_addr, bias_data_in}), 64'd0);
  endtask

  initial begin
    clear_logs();
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Engine traffic while idle must be neither forwarded nor counted.
    conv_valid  = 1'b1;
    conv_result = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    conv_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_conv_valid_forwarded", 64'(mv_cnt), 64'd0);
    check("idle_out_count", 64'(out_count), 64'd0);

    // Layer A: gap-free load, known first bias, done arrives before the last output.
    clear_logs();
    new_stream();
    stream[N_IN + N_W + 0] = 8'h78;
    stream[N_IN + N_W + 1] = 8'h56;
    stream[N_IN + N_W + 2] = 8'h34;
    stream[N_IN + N_W + 3] = 8'h12;
    start_layer();
    check("a_busy_after_start", 64'(busy), 64'd1);
    load_stream(0, N_BYTES, -1);
    check("a_conv_start_high", 64'(conv_start), 64'd1);
    check("a_ready_low_in_start", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    check("a_conv_start_one_cycle", 64'(conv_start), 64'd0);
    verify_load();
    if (b_data_q.size() > 0) begin
      check("a_bias0_value", 64'(b_data_q[0]), 64'h12345678);
      check("a_bias0_addr", 64'(b_addr_q[0]), 64'd0);
    end else begin
      check("a_bias0_present", 64'(b_data_q.size()), 64'd1);
    end
    run_engine(N_OUT, N_OUT - 88, 0);
    wait_done();
    check("a_done_after_last_mvalid", 64'(done_cyc - last_mv_cyc), 64'd1);
    check("a_out_count", 64'(out_count), 64'(N_OUT));
    check("a_mvalid_count", 64'(mv_cnt), 64'(N_OUT));
    check("a_mdata_errors", 64'(mv_bad), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("a_out_count_holds", 64'(out_count), 64'(N_OUT));

    // Abort: reset part-way through the weights.
    clear_logs();
    new_stream();
    start_layer();
    load_stream(0, N_IN + 100, -1);
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    repeat (3) @(posedge clk);
    #1;
    check("abort_in_writes", 64'(in_addr_q.size()), 64'(N_IN));
    check("abort_w_writes", 64'(w_addr_q.size()), 64'd99);
    check("abort_no_start", 64'(start_cnt + b_addr_q.size()), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Layer B: random stream gaps, ignored cmd_start mid-load, extra outputs, late done.
    clear_logs();
    new_stream();
    start_layer();
    check("b_busy_after_start", 64'(busy), 64'd1);
    check("b_out_count_cleared", 64'(out_count), 64'd0);
    load_stream(40, N_BYTES, 500);
    check("b_conv_start_high", 64'(conv_start), 64'd1);
    @(posedge clk); #1;
    verify_load();
    run_engine(N_OUT + 3, -1, 10);
    wait_done();
    check("b_out_count_saturated", 64'(out_count), 64'(N_OUT));
    check("b_mvalid_count", 64'(mv_cnt), 64'(N_OUT + 3));
    check("b_mdata_errors", 64'(mv_bad), 64'd0);
    check("wdog_err_quiet", 64'(wdog_err), 64'd0);

    // A fresh command clears the held count.
    start_layer();
    check("c_out_count_cleared", 64'(out_count), 64'd0);
    check("c_busy", 64'(busy), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
Controller that sequences one QuantizedConvReLU2d layer run.
- Accepts a single 8-bit byte stream (valid/ready) carrying input pixels, then weights, then biases.
- Writes each byte into the engine's input, weight and bias memories at incrementing addresses, then pulses the engine start.
- Forwards conv_result/conv_valid to an output stream and reports layer completion once the engine is done and every output has been seen.

Parameters:
INPUT_CHANNELS, 1, input channels (C)
OUTPUT_CHANNELS, 32, output channels (K)
KERNEL_SIZE, 3, square kernel side (KS)
INPUT_WIDTH, 30, padded input width (W)
INPUT_HEIGHT, 30, padded input height (H)
WDOG_CYCLES, 1000000, watchdog limit in RUN state (used only with the optional feature)

Ports:
clk  in  1  single clock; all logic on the rising edge
rst  in  1  reset, asynchronous and active-high
cmd_start  in  1  one-cycle request to begin a layer; ignored unless idle
busy  out  1  high from accepted cmd_start until layer_done
layer_done  out  1  one-cycle pulse when the layer completes
s_data  in  8  parameter/input byte stream
s_valid  in  1  stream valid
s_ready  out  1  stream ready; high only in the LOAD_* states
conv_start  out  1  one-cycle start pulse to the engine
conv_done  in  1  engine done
input_data_in, input_data_we, input_data_addr  out  8/1/clog2(C*H*W)  engine input memory write
weight_data_in, weight_data_we, weight_data_addr  out  8/1/clog2(K*C*KS*KS)  engine weight memory write
bias_data_in, bias_data_we, bias_data_addr  out  32/1/clog2(K)  engine bias memory write
conv_result  in  8  engine output
conv_valid  in  1  engine output valid
m_data  out  8  registered copy of conv_result
m_valid  out  1  registered copy of conv_valid (no backpressure)
out_count  out  clog2(K*(H-2)*(W-2)+1)  outputs forwarded this layer
wdog_err  out  1  watchdog flag (tied 0 without the optional feature)

Behaviour:
Constants: N_IN = C*H*W, N_W = K*C*KS*KS, N_B = K, N_OUT = K*(H-KS+1)*(W-KS+1).
Defaults give 900 / 288 / 32 / 25088.

Reset: every output is 0 and the state is IDLE. Asserting rst mid-layer aborts immediately; no write enable or start is issued afterwards.

States:
- IDLE: on cmd_start, clear counters and out_count, set busy, go to LOAD_IN.
- LOAD_IN: a byte transfers when s_valid & s_ready. In the next cycle the block drives input_data_we=1 with addr = the byte's ordinal and data = the byte. After the N_IN-th transfer, go to LOAD_W.
- LOAD_W: same rule on the weight port, addresses 0..N_W-1. After the N_W-th transfer, go to LOAD_B.
- LOAD_B: bytes are assembled little-endian, 4 per bias (the first byte is bits 7:0). After each 4th byte, one cycle with bias_data_we=1 and addr = bias index. After N_B biases, go to START.
- START: conv_start=1 for exactly one cycle, then go to RUN.
- RUN: s_ready=0. Every conv_valid cycle gives m_valid=1 and m_data=conv_result one cycle later, and out_count increments. Record conv_done sticky. When sticky done AND out_count==N_OUT, go to DONE. The order of the done and the last output does not matter.
- DONE: layer_done=1 for one cycle, busy=0, return to IDLE. out_count holds until the next cmd_start.

Write latency: exactly 1 cycle from a stream transfer to the matching we pulse. At most one we per cycle. we is never high outside LOAD_*, except the final bias write, which may fall in the first START cycle.
Bubbles: s_valid low stalls the counters with no write issued.
cmd_start while busy is ignored.
conv_valid outside RUN is ignored; it is not counted and not forwarded.
out_count saturates at N_OUT; extra conv_valid pulses are still forwarded but not counted.

Optional Feature:
Macro CONV_SEQ_WATCHDOG_EN.
- Defined: a counter runs in RUN and resets on every conv_valid. When it reaches WDOG_CYCLES, wdog_err sets sticky and the FSM goes to DONE (layer_done still pulses). wdog_err clears on the next accepted cmd_start or on rst.
- Undefined: no counter; wdog_err is tied to 0; RUN waits indefinitely.

Decomposition:
Package conv_seq_pkg holds:
- the state enum (IDLE, LOAD_IN, LOAD_W, LOAD_B, START, RUN, DONE);
- functions computing N_IN, N_W, N_B, N_OUT and the address widths from the parameters.

One sub-module, conv_seq_bias_packer: a 4-byte little-endian assembler that emits a 32-bit word plus a valid pulse, with clear on rst and on cmd_start.

Test Plan:
- Default params; stream 900+288+128 bytes with no gaps → input we addr 0..899, weight we addr 0..287, 32 bias writes, then exactly one conv_start; total s_ready-high transfers = 1316.
- Bias bytes 0x78,0x56,0x34,0x12 for bias 0 → bias_data_in=0x12345678 at bias_data_addr=0.
- Random s_valid gaps during load → write sequence identical to the no-gap case; no we without a preceding transfer.
- Engine model asserts conv_done before the last of 25088 conv_valid pulses → layer_done only 1 cycle after the final m_valid; out_count=25088.
- rst asserted mid-LOAD_W at weight 100 → all outputs 0 immediately; a new cmd_start restarts at input addr 0.
- With CONV_SEQ_WATCHDOG_EN and WDOG_CYCLES=50, engine silent after start → wdog_err=1 and layer_done pulse 50 cycles after the RUN entry.
